vga_fb_display: RTL and testbench

- Second-generation Avalon-MM VGA framebuffer peripheral for 640x480 at 25 MHz pixel rate, derived from clk50 with one pixel every two cycles.
- Generalised from 1 bpp to BPP bits per pixel through a 2^BPP-entry 24-bit palette.
- Adds a double-buffered framebuffer with a tear-free page swap at vertical blank.
- Adds a fixed, aligned read pipeline and readable control/status registers.
- Sits between the HPS lightweight bridge and the board VGA DAC; the software renderer draws into the back page.

---
 rtl/vga_fb_display.sv | 193 +++++++++++++++++++
 tb/tb_vga_fb_display.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_display.sv
// vga_fb_display: double-buffered Avalon-MM VGA framebuffer, 640x480 @ 25 MHz.
// Define VGA_TEST_PATTERN_EN to add the CTRL bit2 colour-bar test pattern.
module vga_fb_display #(
  parameter int   BPP        = 2,
  parameter int   ADDR_W     = 17,
  parameter logic RESET_PAGE = 1'b0
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);
  localparam int PPW   = 32 / BPP;
  localparam int PW    = $clog2(PPW);
  localparam int NPAL  = 1 << BPP;
  localparam int OFF_W = ADDR_W - 2;
  localparam int DEPTH = 1 << (ADDR_W - 1);
  localparam logic [7:0] PAL_END = 8'(16 + NPAL);

  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic             active, hs_raw, vs_raw;
  logic             adv, fetch, frame_start, swap_cyc;
  logic             adv_d1, fetch_d1;
  logic [OFF_W-1:0] word_cnt, rd_word;
  logic [31:0]      fb_mem [DEPTH];
  logic [31:0]      ram_q, shreg;
  logic [BPP-1:0]   pix_idx;
  logic [23:0]      palette [NPAL];
  logic [23:0]      pal_rgb, rgb_q;
  logic [3:0][3:0]  sd;
  logic             front_page, swap_pending;
  logic             ctrl_page, ctrl_fb, ctrl_pat;
  logic             reg_sel, fb_we, wr_ctrl, wr_pal;
  logic             sel_ctrl, sel_stat, pal_hit;
  logic [7:0]       reg_addr;
  logic [BPP-1:0]   pal_idx;
  logic [31:0]      rd_mux;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == 11'd1599) begin
      hcount <= '0;
      vcount <= (vcount == 10'd524) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign active      = (hcount < 11'd1280) && (vcount < 10'd480);
  assign hs_raw      = !(hcount >= 11'd1312 && hcount <= 11'd1503);
  assign vs_raw      = !(vcount == 10'd490 || vcount == 10'd491);
  assign adv         = active && !hcount[0];
  assign fetch       = adv && (hcount[PW:1] == '0);
  assign frame_start = (hcount == '0) && (vcount == '0);
  assign swap_cyc    = (hcount == '0) && (vcount == 10'd480);
  assign rd_word     = frame_start ? '0 : word_cnt;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      adv_d1   <= 1'b0;
      fetch_d1 <= 1'b0;
    end else begin
      if (fetch) word_cnt <= rd_word + 1'b1;
      adv_d1   <= adv;
      fetch_d1 <= fetch;
    end
  end

  // Framebuffer: one write port for the bus, one read port for scanout.
  assign fb_we = chipselect && write && !address[ADDR_W-1];

  always_ff @(posedge clk50) begin
    if (fb_we) fb_mem[address[ADDR_W-2:0]] <= writedata;
    ram_q <= fb_mem[{front_page, rd_word}];
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) shreg <= '0;
    else if (fetch_d1) shreg <= ram_q;
    else if (adv_d1) shreg <= shreg >> BPP;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]     x_d1, x_d2;
  logic [BPP-1:0] bar;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ctrl_pat <= 1'b0;
      x_d1     <= '0;
      x_d2     <= '0;
    end else begin
      if (wr_ctrl) ctrl_pat <= writedata[2];
      x_d1 <= hcount[10:1];
      x_d2 <= x_d1;
    end
  end

  assign bar     = BPP'(x_d2 / 10'd80);
  assign pix_idx = ctrl_pat ? bar : shreg[BPP-1:0];
`else
  assign ctrl_pat = 1'b0;
  assign pix_idx  = shreg[BPP-1:0];
`endif

  // Sync bundle {clk, hs, vs, blank_n} rides alongside the pixel pipe.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sd      <= {4{4'b0110}};
      pal_rgb <= '0;
      rgb_q   <= '0;
    end else begin
      sd      <= {sd[2:0], {hcount[0], hs_raw, vs_raw, active}};
      pal_rgb <= palette[pix_idx];
      rgb_q   <= (!sd[2][0] || ctrl_fb) ? '0 : pal_rgb;
    end
  end

  assign VGA_CLK     = sd[3][3];
  assign VGA_HS      = sd[3][2];
  assign VGA_VS      = sd[3][1];
  assign VGA_BLANK_n = sd[3][0];
  assign VGA_SYNC_n  = 1'b0;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

  assign reg_sel  = address[ADDR_W-1];
  assign reg_addr = address[7:0];
  assign sel_ctrl = reg_sel && (reg_addr == 8'h00);
  assign sel_stat = reg_sel && (reg_addr == 8'h01);
  assign pal_hit  = reg_sel && (reg_addr >= 8'h10) && (reg_addr < PAL_END);
  assign pal_idx  = reg_addr[BPP-1:0];
  assign wr_ctrl  = chipselect && write && sel_ctrl;
  assign wr_pal   = chipselect && write && pal_hit;

  // A CTRL write on the swap cycle defers the swap to the next frame.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ctrl_page    <= RESET_PAGE;
      ctrl_fb      <= 1'b0;
      front_page   <= RESET_PAGE;
      swap_pending <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_page    <= writedata[0];
      ctrl_fb      <= writedata[1];
      swap_pending <= 1'b1;
    end else if (swap_cyc && swap_pending) begin
      front_page   <= ctrl_page;
      swap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++)
        palette[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
    end else if (wr_pal) begin
      palette[pal_idx] <= writedata[23:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: rd_mux = {29'd0, ctrl_pat, ctrl_fb, ctrl_page};
      sel_stat: rd_mux = {29'd0, vcount >= 10'd480, swap_pending, front_page};
      pal_hit:  rd_mux = {8'd0, palette[pal_idx]};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) readdata <= '0;
    else if (chipselect && read) readdata <= rd_mux;
  end
endmodule

// File: tb/tb_vga_fb_display.sv
// tb_vga_fb_display: directed vectors for the VGA framebuffer peripheral.
// Time reference cyc counts clk50 edges since the last reset release.
module tb_vga_fb_display;
  localparam int AW = 17;
  localparam logic [AW-1:0] REG = 17'h10000;
  localparam int W0 = 1680004;
  localparam int W1 = 2520004;

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  int total = 0;
  int bad = 0;
  int cyc;
  int nz = 0, hs_falls = 0, vs_falls = 0;
  logic hs_p = 1'b1, vs_p = 1'b1;

  vga_fb_display dut (
    .clk50(clk50), .reset(reset),
    .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #10 clk50 = ~clk50;

  always_ff @(posedge clk50 or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (!reset && cyc >= W0 && cyc < W1) begin
      if ({VGA_R, VGA_G, VGA_B} != 24'd0) nz++;
      if (hs_p && !VGA_HS) hs_falls++;
      if (vs_p && !VGA_VS) vs_falls++;
    end
    hs_p = VGA_HS;
    vs_p = VGA_VS;
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    string         name;
  } bus_vec_t;

  typedef struct {
    int          base;
    int          p;
    logic [23:0] rgb;
  } px_vec_t;

  bus_vec_t bv [19];
  px_vec_t  pv [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk50);
    if (cyc != t) begin
      total++;
      bad++;
      $display("FAIL sched: at cyc %0d want %0d", cyc, t);
    end
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk50);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic set_pal();
    bus_wr(REG | 17'h11, 32'h0000FF);
    bus_wr(REG | 17'h12, 32'h00FF00);
    bus_wr(REG | 17'h13, 32'hFF0000);
  endtask

  task automatic px_chk(input int i);
    for (int j = 0; j < 2; j++) begin
      wait_cyc(pv[i].base + 2 * pv[i].p + 4 + j);
      chk($sformatf("px%0d_%0d", pv[i].p, j),
          {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, pv[i].rgb});
    end
  endtask

  initial begin
    logic [31:0] d;
    bv[0]  = '{1, 17'd0,            32'h0,        "fb_p0w0"};
    bv[1]  = '{1, 17'd40,           32'h0000001B, "fb_p0w40"};
    bv[2]  = '{1, 17'h08000,        32'h000000E4, "fb_p1w0"};
    bv[3]  = '{0, REG | 17'h10,     32'h000000,   "pal0_rst"};
    bv[4]  = '{0, REG | 17'h12,     32'hFFFFFF,   "pal2_rst"};
    bv[5]  = '{1, REG | 17'h11,     32'h0000FF,   "pal1_wr"};
    bv[6]  = '{1, REG | 17'h12,     32'h00FF00,   "pal2_wr"};
    bv[7]  = '{1, REG | 17'h13,     32'hFFFF0000, "pal3_wr"};
    bv[8]  = '{0, REG | 17'h11,     32'h0000FF,   "pal1_rd"};
    bv[9]  = '{0, REG | 17'h12,     32'h00FF00,   "pal2_rd"};
    bv[10] = '{0, REG | 17'h13,     32'hFF0000,   "pal3_rd"};
    bv[11] = '{0, REG | 17'h01,     32'h0,        "stat_idle"};
    bv[12] = '{0, 17'd40,           32'h0,        "fb_rd_zero"};
    bv[13] = '{0, REG | 17'h14,     32'h0,        "pal_oob"};
    bv[14] = '{1, REG | 17'h05,     32'hFFFFFFFF, "unmap_wr"};
    bv[15] = '{0, REG | 17'h05,     32'h0,        "unmap_rd"};
    bv[16] = '{1, REG | 17'h00,     32'h7,        "ctrl_wr7"};
`ifdef VGA_TEST_PATTERN_EN
    bv[17] = '{0, REG | 17'h00,     32'h7,        "ctrl_rd"};
`else
    bv[17] = '{0, REG | 17'h00,     32'h3,        "ctrl_rd"};
`endif
    bv[18] = '{0, REG | 17'h01,     32'h2,        "stat_pend"};

    pv[0] = '{1600,   0, 24'hFF0000};
    pv[1] = '{1600,   1, 24'h00FF00};
    pv[2] = '{1600,   2, 24'h0000FF};
    pv[3] = '{1600,   3, 24'h000000};
    pv[4] = '{1600,   4, 24'h000000};
    pv[5] = '{840000, 0, 24'h000000};
    pv[6] = '{840000, 1, 24'h0000FF};
    pv[7] = '{840000, 2, 24'h00FF00};
    pv[8] = '{840000, 3, 24'hFF0000};

    repeat (3) @(negedge clk50);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_hs", {31'd0, VGA_HS}, 32'h1);
    chk("rst_vs", {31'd0, VGA_VS}, 32'h1);
    chk("rst_blank", {31'd0, VGA_BLANK_n}, 32'h0);
    chk("sync_n", {31'd0, VGA_SYNC_n}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (bv[i].wr) bus_wr(bv[i].addr, bv[i].data);
      else rd_chk(bv[i].name, bv[i].addr, bv[i].data);
    end

    bus_rd(REG | 17'h13, d);
    address = REG | 17'h01;
    @(negedge clk50);
    chk("rd_hold", readdata, 32'hFF0000);

    wait_cyc(1315);
    chk("hs_pre", {31'd0, VGA_HS}, 32'h1);
    wait_cyc(1316);
    chk("hs_fall", {31'd0, VGA_HS}, 32'h0);
    wait_cyc(1317);
    chk("vga_clk", {31'd0, VGA_CLK}, 32'h1);

    wait_cyc(160000);
    bus_wr(REG, 32'h1);
    rd_chk("stat_a_pend", REG | 17'h01, 32'h2);

    wait_cyc(320000);
    reset = 1'b1;
    @(negedge clk50);
    chk("mid_rst_rd", readdata, 32'h0);
    chk("mid_rst_hs", {31'd0, VGA_HS}, 32'h1);
    reset = 1'b0;
    rd_chk("stat_after_rst", REG | 17'h01, 32'h0);
    wait_cyc(3);
    chk("blank_lat3", {31'd0, VGA_BLANK_n}, 32'h0);
    wait_cyc(4);
    chk("blank_lat4", {31'd0, VGA_BLANK_n}, 32'h1);
    chk("first_px", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    set_pal();
    wait_cyc(1316);
    chk("hs_fall_rst", {31'd0, VGA_HS}, 32'h0);

    for (int i = 0; i < 5; i++) px_chk(i);
    wait_cyc(1600 + 1290 + 4);
    chk("hblank_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);

    wait_cyc(160000);
    bus_wr(REG, 32'h1);
    rd_chk("stat_b_pend", REG | 17'h01, 32'h2);
    wait_cyc(767990);
    rd_chk("stat_pre_swap", REG | 17'h01, 32'h2);
    wait_cyc(768001);
    rd_chk("stat_swapped", REG | 17'h01, 32'h5);

    for (int i = 5; i < 9; i++) px_chk(i);

    wait_cyc(856000);
    bus_wr(REG, 32'h3);
    wait_cyc(1608000);
    bus_wr(REG, 32'h2);
    rd_chk("stat_coincide", REG | 17'h01, 32'h7);
    wait_cyc(2447990);
    rd_chk("ctrl_fb", REG, 32'h2);
    rd_chk("stat_late_pre", REG | 17'h01, 32'h3);
    wait_cyc(2448001);
    rd_chk("stat_late_swap", REG | 17'h01, 32'h4);

    wait_cyc(W1 + 1);
    chk("fb_black_px", nz, 0);
    chk("fb_hs_falls", hs_falls, 525);
    chk("fb_vs_falls", vs_falls, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
